// File: rtl/led_seq_pkg.sv
// ============================================================
// led_seq_pkg : mode encodings and start patterns for led_pattern_seq
// Rev 1.0
// ============================================================
`default_nettype none

package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_ROT_L = 2'd0,
      MODE_ROT_R = 2'd1,
      MODE_PING  = 2'd2,
      MODE_FILL  = 2'd3
   } mode_t;

   // Widest LED bank the start-pattern helper can describe; callers truncate.
   localparam int LED_MAX = 64;

   function automatic logic [LED_MAX-1:0] start_pattern(input mode_t m, input int led_num);
      logic [LED_MAX-1:0] pat;
      if (m == MODE_ROT_R)
         pat = LED_MAX'(1) << (led_num - 1);
      else
         pat = LED_MAX'(1);
      return pat;
   endfunction

endpackage

`default_nettype wire

// File: rtl/led_tick_gen.sv
// ============================================================
// led_tick_gen : free-running step timer with a registered tick
// Rev 1.0
// ============================================================
`default_nettype none

module led_tick_gen #(
   parameter int CNT_MAX = 24_999_999
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic en,
   output logic tick
);

   localparam int          W        = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [W-1:0] CNT_LAST = W'(CNT_MAX);
   localparam logic [W-1:0] CNT_PRE  = W'(CNT_MAX - 1);

   logic [W-1:0] cnt;
   logic         tick_r;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt    <= '0;
         tick_r <= 1'b0;
      end else if (en) begin
         tick_r <= (cnt == CNT_PRE);
         cnt    <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
   end

   // tick_r survives a pause so a step pending at cnt==CNT_MAX is not lost.
   assign tick = tick_r & en;

endmodule

`default_nettype wire

// File: rtl/led_pattern_seq.sv
// ============================================================
// led_pattern_seq : LED sequencer (rotate L/R, ping-pong, bar fill)
// Rev 1.0
// ============================================================
`default_nettype none

module led_pattern_seq
   import led_seq_pkg::*;
#(
   parameter int LED_NUM        = 8,
   parameter int CNT_MAX        = 24_999_999,
   parameter int LED_ACTIVE_LOW = 1
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               en,
   input  logic [1:0]         mode,
   output logic               step_pulse,
   output logic [LED_NUM-1:0] led_out
);

   localparam logic [LED_NUM-1:0] ONE = LED_NUM'(1);

   logic               tick;
   logic [LED_NUM-1:0] pattern;
   logic [LED_NUM-1:0] next_adv;
   logic               dir_up;
   logic               next_dir_up;
   mode_t              mode_act;

   led_tick_gen #(
      .CNT_MAX (CNT_MAX)
   ) u_tick (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .en      (en),
      .tick    (tick)
   );

   always_comb begin
      next_adv    = pattern;
      next_dir_up = dir_up;
      case (mode_act)
         MODE_ROT_L: next_adv = (pattern << 1) | (pattern >> (LED_NUM - 1));
         MODE_ROT_R: next_adv = (pattern >> 1) | (pattern << (LED_NUM - 1));
         MODE_PING: begin
            // A single LED has nowhere to bounce, so it simply holds.
            if (LED_NUM > 1) begin
               if (dir_up) begin
                  if (pattern[LED_NUM-1]) begin
                     next_adv    = pattern >> 1;
                     next_dir_up = 1'b0;
                  end else begin
                     next_adv = pattern << 1;
                  end
               end else begin
                  if (pattern[0]) begin
                     next_adv    = pattern << 1;
                     next_dir_up = 1'b1;
                  end else begin
                     next_adv = pattern >> 1;
                  end
               end
            end
         end
         MODE_FILL: next_adv = (&pattern) ? '0 : ((pattern << 1) | ONE);
         default:   next_adv = pattern;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pattern    <= ONE;
         dir_up     <= 1'b1;
         mode_act   <= MODE_ROT_L;
         step_pulse <= 1'b0;
      end else begin
         step_pulse <= tick;
         if (tick) begin
            if (mode == mode_act) begin
               pattern <= next_adv;
               dir_up  <= next_dir_up;
            end else begin
               mode_act <= mode_t'(mode);
               pattern  <= LED_NUM'(start_pattern(mode_t'(mode), LED_NUM));
               dir_up   <= 1'b1;
            end
         end
      end
   end

   generate
      if (LED_ACTIVE_LOW != 0) begin : g_active_low
         assign led_out = ~pattern;
      end else begin : g_active_high
         assign led_out = pattern;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
// ============================================================
// tb_led_pattern_seq : directed self-checking bench for led_pattern_seq
// Rev 1.0
// ============================================================
`default_nettype none
`timescale 1ns/1ps

module tb_led_pattern_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // A: 8 LEDs, active-low; B: 4 LEDs; C: 8 LEDs active-high; D: 1 LED, CNT_MAX=1
   logic       rst_a = 1'b1, en_a = 1'b1; logic [1:0] mode_a = 2'd0;
   logic       sp_a;  logic [7:0] led_a;
   logic       rst_b = 1'b1, en_b = 1'b1; logic [1:0] mode_b = 2'd2;
   logic       sp_b;  logic [3:0] led_b;
   logic       rst_c = 1'b1, en_c = 1'b1; logic [1:0] mode_c = 2'd2;
   logic       sp_c;  logic [7:0] led_c;
   logic       rst_d = 1'b1, en_d = 1'b1; logic [1:0] mode_d = 2'd0;
   logic       sp_d;  logic [0:0] led_d;

   int passes = 0;
   int fails  = 0;
   int total  = 0;

   led_pattern_seq #(.LED_NUM(8), .CNT_MAX(4), .LED_ACTIVE_LOW(1)) u_a (
      .sys_clk(clk), .sys_rst(rst_a), .en(en_a), .mode(mode_a), .step_pulse(sp_a), .led_out(led_a));
   led_pattern_seq #(.LED_NUM(4), .CNT_MAX(4), .LED_ACTIVE_LOW(0)) u_b (
      .sys_clk(clk), .sys_rst(rst_b), .en(en_b), .mode(mode_b), .step_pulse(sp_b), .led_out(led_b));
   led_pattern_seq #(.LED_NUM(8), .CNT_MAX(4), .LED_ACTIVE_LOW(0)) u_c (
      .sys_clk(clk), .sys_rst(rst_c), .en(en_c), .mode(mode_c), .step_pulse(sp_c), .led_out(led_c));
   led_pattern_seq #(.LED_NUM(1), .CNT_MAX(1), .LED_ACTIVE_LOW(0)) u_d (
      .sys_clk(clk), .sys_rst(rst_d), .en(en_d), .mode(mode_d), .step_pulse(sp_d), .led_out(led_d));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [31:0] exp_a [9]  = '{32'hFD, 32'hFB, 32'hF7, 32'hEF, 32'hDF, 32'hBF, 32'h7F, 32'hFE, 32'hFD};
   logic [31:0] exp_bp [8] = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h4, 32'h2, 32'h1, 32'h2};
   logic [31:0] exp_bf [5] = '{32'h3, 32'h7, 32'hF, 32'h0, 32'h1};
   logic [31:0] exp_br [4] = '{32'h4, 32'h2, 32'h1, 32'h8};
   logic [31:0] exp_c [10] = '{32'h01, 32'h02, 32'h04, 32'h08, 32'h10, 32'h20, 32'h40, 32'h80, 32'h40, 32'h20};

   initial begin
      // ---- A: reset values, rot-left with wrap, step period, pause
      cyc(2);
      check("a_rst_led", 32'(led_a), 32'hFE);
      check("a_rst_sp",  32'(sp_a),  32'h0);
      rst_a = 1'b0;
      for (int i = 0; i < 9; i++) begin
         cyc(4);
         check("a_gap_sp", 32'(sp_a), 32'h0);
         cyc(1);
         check("a_step_sp",  32'(sp_a),  32'h1);
         check("a_step_led", 32'(led_a), exp_a[i]);
      end
      cyc(2);
      en_a = 1'b0;
      cyc(10);
      check("a_pause_sp",  32'(sp_a),  32'h0);
      cyc(10);
      check("a_pause_led", 32'(led_a), 32'hFD);
      check("a_pause_sp2", 32'(sp_a),  32'h0);
      en_a = 1'b1;
      cyc(2);
      check("a_resume_gap", 32'(sp_a), 32'h0);
      cyc(1);
      check("a_resume_sp",  32'(sp_a),  32'h1);
      check("a_resume_led", 32'(led_a), 32'hFB);

      // ---- B: ping-pong load and bounce, fill, late mode change to rot-right
      rst_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc(4);
         check("b_ping_gap", 32'(sp_b), 32'h0);
         cyc(1);
         check("b_ping_sp",  32'(sp_b),  32'h1);
         check("b_ping_led", 32'(led_b), exp_bp[i]);
      end
      cyc(2);
      mode_b = 2'd3;
      cyc(2);
      check("b_fill_hold", 32'(led_b), 32'h2);
      cyc(1);
      check("b_fill_load", 32'(led_b), 32'h1);
      for (int i = 0; i < 5; i++) begin
         cyc(5);
         check("b_fill_sp",  32'(sp_b),  32'h1);
         check("b_fill_led", 32'(led_b), exp_bf[i]);
      end
      cyc(2);
      mode_b = 2'd1;
      cyc(2);
      check("b_rotr_hold", 32'(led_b), 32'h1);
      check("b_rotr_gap",  32'(sp_b),  32'h0);
      cyc(1);
      check("b_rotr_load", 32'(led_b), 32'h8);
      for (int i = 0; i < 4; i++) begin
         cyc(5);
         check("b_rotr_led", 32'(led_b), exp_br[i]);
      end

      // ---- C: async reset mid-bounce, mode reverts to rot-left
      rst_c = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(5);
         check("c_ping_led", 32'(led_c), exp_c[i]);
      end
      cyc(2);
      #2;
      rst_c = 1'b1;
      #1;
      check("c_async_led", 32'(led_c), 32'h01);
      check("c_async_sp",  32'(sp_c),  32'h0);
      mode_c = 2'd0;
      cyc(1);
      rst_c = 1'b0;
      cyc(4);
      check("c_post_led", 32'(led_c), 32'h01);
      cyc(1);
      check("c_post_sp",  32'(sp_c),  32'h1);
      check("c_post_adv", 32'(led_c), 32'h02);

      // ---- D: single LED, CNT_MAX=1
      rst_d = 1'b0;
      cyc(1);
      check("d_gap_sp", 32'(sp_d), 32'h0);
      cyc(1);
      check("d_rot_sp",  32'(sp_d),  32'h1);
      check("d_rot_led", 32'(led_d), 32'h1);
      cyc(2);
      check("d_rot_led2", 32'(led_d), 32'h1);
      mode_d = 2'd3;
      cyc(2);
      check("d_fill_load", 32'(led_d), 32'h1);
      cyc(2);
      check("d_fill_zero", 32'(led_d), 32'h0);
      check("d_fill_sp",   32'(sp_d),  32'h1);
      cyc(2);
      check("d_fill_one",  32'(led_d), 32'h1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

`default_nettype wire
